lcd_write_engine: RTL
=====================

# lcd_write_engine

Parametrised 8080-style LCD write engine: buffers command/data words from a valid/ready stream in a FIFO and drives the panel's chip-select, data/command, write-strobe and data bus with programmable strobe timing. Successor to the fixed 16-bit LCD DMA conduit: bus width, pixel width, FIFO depth and strobe timing are now configurable. A narrow bus splits each pixel into two beats. Sits between the LCD DMA/CPU stream source and the top-level LCD pins.

## Interface
- PIX_W, 16: input word width.
- BUS_W, 16: LCD bus width; legal values are PIX_W (one beat per word) or PIX_W/2 (split mode).
- FIFO_DEPTH, 16: FIFO entries; power of two, at least 2.
- TW, 4: width of the strobe-timing config fields.
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  FIFO can accept; equals (fifo_level < FIFO_DEPTH).
- in_data  in  PIX_W  word to send.
- in_dc  in  1  1 = pixel/data word, 0 = command word.
- enable  in  1  1 lets the FSM start words; FIFO accepts regardless.
- cfg_wr_low  in  TW  wr_n low time minus 1, in cycles.
- cfg_wr_high  in  TW  wr_n high time minus 1, in cycles.
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- lcd_cs_n, lcd_d_c_n, lcd_wr_n  out  1  panel strobes, all registered.
- lcd_data  out  BUS_W  panel data bus, registered.

## Operation
- Push when in_valid && in_ready. Pop happens only in IDLE (or at the end of WR_HIGH) when enable=1 and the FIFO is non-empty.
- Push and pop in the same cycle leaves fifo_level unchanged. Push while full cannot occur because in_ready is low.
- FSM states: IDLE, SETUP, WR_LOW, WR_HIGH.
  - IDLE -> SETUP on pop. The popped word, in_dc and both cfg fields are latched per word; cfg changes mid-word have no effect. Beat count is set to 2 for a data word in split mode, otherwise 1.
  - SETUP, 1 cycle: lcd_cs_n=0, lcd_d_c_n=dc, lcd_data=current beat, lcd_wr_n=1.
  - WR_LOW, cfg_wr_low+1 cycles, lcd_wr_n=0.
  - WR_HIGH, cfg_wr_high+1 cycles, lcd_wr_n=1. lcd_data and lcd_d_c_n are held through the whole state.
  - At the end of WR_HIGH:
    - beats remain: go to SETUP with the next beat.
    - else if enable=1 and the FIFO is non-empty: pop and go to SETUP, with lcd_cs_n kept low.
    - else: go to IDLE, with lcd_cs_n=1.
- Split-mode beat order: high half first, then low half.
- Command words are always a single beat carrying in_data[BUS_W-1:0].
- Dropping enable mid-word finishes the current word, including all its beats, then returns to IDLE. The FIFO contents are retained.
- Reset values: lcd_cs_n=1, lcd_wr_n=1, lcd_d_c_n=1, lcd_data=0, fifo_level=0, busy=0, state=IDLE.
- Reset asserted mid-transfer aborts immediately: strobes return high and the FIFO is flushed.

## Timing
- Word accepted at edge k: busy=1 after edge k. With enable=1 and the FSM idle, pop and SETUP outputs appear after edge k+1, and lcd_wr_n falls after edge k+2.
- Beat period is 3 + cfg_wr_low + cfg_wr_high cycles. Data setup to the wr_n fall is 1 cycle. Data hold after the wr_n rise is cfg_wr_high+1 cycles.
- in_ready reflects occupancy after the previous edge; there is no combinational path from in_valid.
- The last word ends after its WR_HIGH; lcd_cs_n goes high and busy=0 on the following edge (FIFO empty).

## Test plan
- **Reset:** hold reset; check cs_n, wr_n and d_c_n = 1, lcd_data=0, in_ready=1, fifo_level=0. Assert reset mid-WR_LOW; check wr_n and cs_n return high within the same cycle and level=0.
- **Single command:** BUS_W=16, L=2, H=1, push cmd 0x002C. Expect d_c_n=0, data 0x002C, wr_n low for exactly 3 cycles, total 6 cycles with cs_n low, then cs_n=1 and busy=0.
- **Back-to-back pixels:** push 0x1111, 0x2222, 0x3333. Expect cs_n held low continuously, three wr_n pulses 6 cycles apart, d_c_n=1 throughout.
- **Split mode:** BUS_W=8, PIX_W=16, L=0, H=0. Data 0xABCD produces beats 0xAB then 0xCD, 3 cycles each. Command 0x002A produces a single beat 0x2A with d_c_n=0.
- **FIFO full:** enable=0, push 16 words. Check level=16 and in_ready=0, and that a 17th valid is not accepted. Raise enable; check all 16 words emerge in order and level decrements by 1 per pop.
- **Enable drop and cfg change mid-word:** in split mode, drop enable during the first beat. Check both beats complete, then IDLE with level unchanged. Also change cfg_wr_low mid-word; check the current word keeps its latched timing.

Source files
------------

// File: rtl/lcd_write_engine_if.sv
// Valid/ready word stream feeding the LCD write engine.
// The source drives valid/data/dc; the engine returns ready.
interface lcd_write_engine_if #(
  parameter int PIX_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_data;
  logic             in_dc;

  modport master (output in_valid, output in_data, output in_dc, input in_ready);
  modport slave  (input in_valid, input in_data, input in_dc, output in_ready);
endinterface

// File: rtl/lcd_write_engine.sv
// 8080-style LCD write engine: a word FIFO feeding a SETUP/WR_LOW/WR_HIGH strobe
// sequencer with per-word latched timing and optional two-beat split for narrow buses.
module lcd_write_engine #(
  parameter int PIX_W      = 16,
  parameter int BUS_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int TW         = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  lcd_write_engine_if.slave             s_in,
  input  logic                          enable,
  input  logic [TW-1:0]                 cfg_wr_low,
  input  logic [TW-1:0]                 cfg_wr_high,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          lcd_cs_n,
  output logic                          lcd_d_c_n,
  output logic                          lcd_wr_n,
  output logic [BUS_W-1:0]              lcd_data
);

  localparam int               AW       = $clog2(FIFO_DEPTH);
  localparam int               LW       = AW + 1;
  localparam logic [LW-1:0]    FULL_LVL = LW'(FIFO_DEPTH);
  localparam bit               SPLIT    = (BUS_W != PIX_W);

  typedef enum logic [1:0] {IDLE, SETUP, WR_LOW, WR_HIGH} state_t;

  logic [PIX_W:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;

  state_t           r_state;
  state_t           w_nextState;
  logic [TW-1:0]    r_cnt;
  logic [TW-1:0]    w_nextCnt;
  logic             r_second;
  logic [PIX_W-1:0] r_word;
  logic [TW-1:0]    r_cfgLow;
  logic [TW-1:0]    r_cfgHigh;

  logic             r_lcdCsN;
  logic             r_lcdDcN;
  logic             r_lcdWrN;
  logic [BUS_W-1:0] r_lcdData;

  logic             w_push;
  logic             w_pop;
  logic             w_nextBeat;
  logic             w_empty;
  logic             w_canPop;
  logic             w_headDc;
  logic [PIX_W-1:0] w_headData;
  logic [BUS_W-1:0] w_headBeat;

  assign s_in.in_ready = (r_level != FULL_LVL);
  assign w_push        = s_in.in_valid && s_in.in_ready;
  assign w_empty       = (r_level == '0);
  assign w_canPop      = enable && !w_empty;
  assign {w_headDc, w_headData} = r_mem[r_rdPtr];

  // A split data word leaves with its high half first; commands always use the low bits.
  assign w_headBeat = (SPLIT && w_headDc) ? w_headData[PIX_W-1 -: BUS_W]
                                          : w_headData[BUS_W-1:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {s_in.in_dc, s_in.in_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A pending second beat outranks enable, so a dropped enable still finishes the word.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_pop       = 1'b0;
    w_nextBeat  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_canPop) begin
          w_pop       = 1'b1;
          w_nextState = SETUP;
        end
      end
      SETUP: begin
        w_nextState = WR_LOW;
        w_nextCnt   = r_cfgLow;
      end
      WR_LOW: begin
        if (r_cnt == '0) begin
          w_nextState = WR_HIGH;
          w_nextCnt   = r_cfgHigh;
        end else begin
          w_nextCnt = r_cnt - TW'(1);
        end
      end
      WR_HIGH: begin
        if (r_cnt == '0) begin
          if (r_second) begin
            w_nextBeat  = 1'b1;
            w_nextState = SETUP;
          end else if (w_canPop) begin
            w_pop       = 1'b1;
            w_nextState = SETUP;
          end else begin
            w_nextState = IDLE;
          end
        end else begin
          w_nextCnt = r_cnt - TW'(1);
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_second  <= 1'b0;
      r_word    <= '0;
      r_cfgLow  <= '0;
      r_cfgHigh <= '0;
      r_lcdCsN  <= 1'b1;
      r_lcdDcN  <= 1'b1;
      r_lcdWrN  <= 1'b1;
      r_lcdData <= '0;
    end else begin
      r_state  <= w_nextState;
      r_cnt    <= w_nextCnt;
      r_lcdCsN <= (w_nextState == IDLE);
      r_lcdWrN <= (w_nextState != WR_LOW);
      if (w_pop) begin
        r_word    <= w_headData;
        r_second  <= SPLIT && w_headDc;
        r_cfgLow  <= cfg_wr_low;
        r_cfgHigh <= cfg_wr_high;
        r_lcdDcN  <= w_headDc;
        r_lcdData <= w_headBeat;
      end else if (w_nextBeat) begin
        r_second  <= 1'b0;
        r_lcdData <= r_word[BUS_W-1:0];
      end
    end
  end

  assign busy       = (r_state != IDLE) || !w_empty;
  assign fifo_level = r_level;
  assign lcd_cs_n   = r_lcdCsN;
  assign lcd_d_c_n  = r_lcdDcN;
  assign lcd_wr_n   = r_lcdWrN;
  assign lcd_data   = r_lcdData;

endmodule
